// File: rtl/jtag_dtm.sv
// jtag_dtm -- JTAG Debug Transport Module (TAP + DTMCS/DMI registers + DM handshake).
//
// The whole block runs on TCK (clk); rst_n is asynchronous, active-low.
// Ports:
//   clk, rst_n            TCK and reset
//   tms_i, tdi_i          TAP inputs, sampled on posedge clk
//   tdo_o                 serial out, updated on negedge clk
//   dtm_req_valid_o       request strobe toward the DM (four-phase with dm_ack_i)
//   dtm_req_data_o        {addr, data, op}; held while dtm_req_valid_o is high
//   dm_ack_i              DM request acknowledge (asynchronous, 2-flop synced)
//   dm_resp_valid_i       DM response strobe (asynchronous, 2-flop synced)
//   dm_resp_data_i        {addr, data, status}; sampled once the synced strobe is seen
//   dtm_ack_o             response acknowledge back to the DM
// Configuration macro JTAG_DTM_IDCODE_EN: when defined the IDCODE instruction
// exists and is the IR reset value; otherwise IR resets to BYPASS.
module jtag_dtm #(
  parameter int          DMI_ADDR_BITS = 6,
  parameter int          DMI_DATA_BITS = 32,
  parameter int          DMI_OP_BITS   = 2,
  parameter logic [31:0] IDCODE_VAL    = 32'h1e200a6d
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic dtm_req_valid_o,
  output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dtm_req_data_o,
  input  logic dm_ack_i,
  input  logic dm_resp_valid_i,
  input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dm_resp_data_i,
  output logic dtm_ack_o
);
  localparam int DMI_W = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
  localparam int RSP_W = DMI_ADDR_BITS + DMI_DATA_BITS;

`ifdef JTAG_DTM_IDCODE_EN
  localparam logic [4:0] IR_RST = 5'h01;
`else
  localparam logic [4:0] IR_RST = 5'h1f;
  // IDCODE_VAL has no effect without the IDCODE instruction.
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VAL;
`endif

  typedef struct packed {
    logic [DMI_ADDR_BITS-1:0] addr;
    logic [DMI_DATA_BITS-1:0] data;
    logic [DMI_OP_BITS-1:0]   op;
  } dmi_t;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_t;

  typedef enum logic [1:0] {R_BYP, R_IDC, R_DTMCS, R_DMI} sel_t;

  tap_t             tap;
  logic [4:0]       ir, ir_sh;
  logic [DMI_W-1:0] dr_sh;
  logic [RSP_W-1:0] last_resp;
  logic             busy, sticky;
  logic [1:0]       ack_sync, rsp_sync;
  sel_t             sel;
  dmi_t             dmi_in;

  logic ack_s, rsp_s;
  assign ack_s = ack_sync[1];
  assign rsp_s = rsp_sync[1];

  // Response status bits carry no information the DTM keeps.
  logic unused_rsp;
  assign unused_rsp = ^dm_resp_data_i[DMI_OP_BITS-1:0];

  assign dmi_in = dmi_t'(dr_sh);

  // ---------------- TAP state machine ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tap <= TLR;
    else begin
      case (tap)
        TLR:     tap <= tms_i ? TLR    : RTI;
        RTI:     tap <= tms_i ? SEL_DR : RTI;
        SEL_DR:  tap <= tms_i ? SEL_IR : CAP_DR;
        CAP_DR:  tap <= tms_i ? EX1_DR : SH_DR;
        SH_DR:   tap <= tms_i ? EX1_DR : SH_DR;
        EX1_DR:  tap <= tms_i ? UPD_DR : PAU_DR;
        PAU_DR:  tap <= tms_i ? EX2_DR : PAU_DR;
        EX2_DR:  tap <= tms_i ? UPD_DR : SH_DR;
        UPD_DR:  tap <= tms_i ? SEL_DR : RTI;
        SEL_IR:  tap <= tms_i ? TLR    : CAP_IR;
        CAP_IR:  tap <= tms_i ? EX1_IR : SH_IR;
        SH_IR:   tap <= tms_i ? EX1_IR : SH_IR;
        EX1_IR:  tap <= tms_i ? UPD_IR : PAU_IR;
        PAU_IR:  tap <= tms_i ? EX2_IR : PAU_IR;
        EX2_IR:  tap <= tms_i ? UPD_IR : SH_IR;
        UPD_IR:  tap <= tms_i ? SEL_DR : RTI;
        default: tap <= TLR;
      endcase
    end
  end

  // ---------------- instruction register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir    <= IR_RST;
      ir_sh <= '0;
    end else begin
      case (tap)
        TLR:     ir    <= IR_RST;
        CAP_IR:  ir_sh <= 5'b00001;
        SH_IR:   ir_sh <= {tdi_i, ir_sh[4:1]};
        UPD_IR:  ir    <= ir_sh;
        default: ;
      endcase
    end
  end

  // Unknown codes fall through to BYPASS.
  always_comb begin
    sel = R_BYP;
    case (ir)
`ifdef JTAG_DTM_IDCODE_EN
      5'h01:   sel = R_IDC;
`endif
      5'h10:   sel = R_DTMCS;
      5'h11:   sel = R_DMI;
      default: sel = R_BYP;
    endcase
  end

  // DMI status includes in-flight; DTMCS.dmistat reports the sticky error.
  logic [DMI_OP_BITS-1:0] dmi_stat;
  logic [31:0]            dtmcs_val;
  assign dmi_stat  = {DMI_OP_BITS{busy | sticky}};
  assign dtmcs_val = {14'h0, 1'b0, 1'b0, 1'b0, 3'd5, {2{sticky}},
                      6'(DMI_ADDR_BITS), 4'd1};

  // ---------------- data register shift path ----------------
  // Each register shifts in at its own MSB so the scan length matches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dr_sh <= '0;
    else if (tap == CAP_DR) begin
      case (sel)
`ifdef JTAG_DTM_IDCODE_EN
        R_IDC:   dr_sh <= DMI_W'(IDCODE_VAL);
`endif
        R_DTMCS: dr_sh <= DMI_W'(dtmcs_val);
        R_DMI:   dr_sh <= {last_resp, dmi_stat};
        default: dr_sh <= '0;
      endcase
    end else if (tap == SH_DR) begin
      case (sel)
        R_DMI:   dr_sh        <= {tdi_i, dr_sh[DMI_W-1:1]};
        R_BYP:   dr_sh[0]     <= tdi_i;
        default: dr_sh[31:0]  <= {tdi_i, dr_sh[31:1]};
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) tdo_o <= 1'b0;
    else        tdo_o <= (tap == SH_IR) ? ir_sh[0] : dr_sh[0];
  end

  // ---------------- DMI launch and DM handshake ----------------
  logic upd_dmi, upd_dtmcs, op_ok;
  assign upd_dmi   = (tap == UPD_DR) && (sel == R_DMI);
  assign upd_dtmcs = (tap == UPD_DR) && (sel == R_DTMCS);
  assign op_ok     = (dmi_in.op == DMI_OP_BITS'(1)) || (dmi_in.op == DMI_OP_BITS'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync        <= '0;
      rsp_sync        <= '0;
      dtm_req_valid_o <= 1'b0;
      dtm_req_data_o  <= '0;
      dtm_ack_o       <= 1'b0;
      busy            <= 1'b0;
      sticky          <= 1'b0;
      last_resp       <= '0;
    end else begin
      ack_sync <= {ack_sync[0], dm_ack_i};
      rsp_sync <= {rsp_sync[0], dm_resp_valid_i};

      if (dtm_req_valid_o && ack_s) dtm_req_valid_o <= 1'b0;

      // Response side: latch on synced strobe, release busy once the DM
      // drops its strobe and the four-phase loop closes.
      if (rsp_s && !dtm_ack_o) begin
        last_resp <= dm_resp_data_i[DMI_W-1:DMI_OP_BITS];
        dtm_ack_o <= 1'b1;
      end else if (dtm_ack_o && !rsp_s) begin
        dtm_ack_o <= 1'b0;
        busy      <= 1'b0;
      end

      // Any DMI access while a transaction is in flight is a busy error.
      if (upd_dmi) begin
        if (busy) sticky <= 1'b1;
        else if (!sticky && op_ok) begin
          dtm_req_data_o  <= dr_sh;
          dtm_req_valid_o <= 1'b1;
          busy            <= 1'b1;
        end
      end

      if (upd_dtmcs) begin
        if (dr_sh[16]) sticky <= 1'b0;
        if (dr_sh[17]) begin
          sticky          <= 1'b0;
          busy            <= 1'b0;
          dtm_req_valid_o <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtag_dtm.sv
// tb_jtag_dtm -- scoreboard bench for jtag_dtm: scan captures and DMI requests
// are queued as expectations when driven and checked when the DUT produces them.
module tb_jtag_dtm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tms_i = 1'b0, tdi_i = 1'b0;
  logic        tdo_o, dtm_req_valid_o, dtm_ack_o;
  logic [39:0] dtm_req_data_o;
  logic        dm_ack_i = 1'b0, dm_resp_valid_i = 1'b0;
  logic [39:0] dm_resp_data_i = '0;

  int tests = 0, fails = 0;
  logic [63:0] scan_q[$];
  logic [39:0] req_q[$];

  jtag_dtm dut (
    .clk(clk), .rst_n(rst_n), .tms_i(tms_i), .tdi_i(tdi_i), .tdo_o(tdo_o),
    .dtm_req_valid_o(dtm_req_valid_o), .dtm_req_data_o(dtm_req_data_o),
    .dm_ack_i(dm_ack_i), .dm_resp_valid_i(dm_resp_valid_i),
    .dm_resp_data_i(dm_resp_data_i), .dtm_ack_o(dtm_ack_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tck(input logic tms, input logic tdi, output logic tdo);
    @(negedge clk); #1;
    tdo = tdo_o; tms_i = tms; tdi_i = tdi;
    @(posedge clk);
  endtask

  task automatic tlr();
    logic t;
    for (int i = 0; i < 5; i++) tck(1'b1, 1'b0, t);
    tck(1'b0, 1'b0, t);
  endtask

  task automatic ir_scan(input logic [4:0] code);
    logic t; logic [63:0] dout;
    dout = '0;
    scan_q.push_back(64'h1);
    tck(1, 0, t); tck(1, 0, t); tck(0, 0, t); tck(0, 0, t);
    for (int i = 0; i < 5; i++) begin
      tck(i == 4, code[i], t);
      dout[i] = t;
    end
    tck(1, 0, t); tck(0, 0, t);
    chk("ir_capture", dout, scan_q.pop_front());
  endtask

  task automatic dr_scan(input string tag, input int n, input logic [39:0] din,
                         input logic [63:0] exp);
    logic t; logic [63:0] dout;
    dout = '0;
    scan_q.push_back(exp);
    tck(1, 0, t); tck(0, 0, t); tck(0, 0, t);
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, din[i], t);
      dout[i] = t;
    end
    tck(1, 0, t); tck(0, 0, t);
    chk(tag, dout, scan_q.pop_front());
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return dtm_req_valid_o;
      default: return dtm_ack_o;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input logic val);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(negedge clk); #1;
      seen = (sig(which) == val);
    end
    chk(tag, seen, 1'b1);
  endtask

  // DMI write/read launch: request expectation is queued with the stimulus.
  task automatic dmi_launch(input string tag, input logic [39:0] req, input logic [63:0] cap);
    req_q.push_back(req);
    dr_scan({tag, "_cap"}, 40, req, cap);
    wait_for({tag, "_valid"}, 0, 1'b1);
    chk({tag, "_data"}, dtm_req_data_o, req_q.pop_front());
  endtask

  task automatic dm_complete(input string tag, input logic [39:0] resp);
    dm_ack_i = 1'b1;
    wait_for({tag, "_vdrop"}, 0, 1'b0);
    dm_ack_i = 1'b0;
    dm_resp_data_i = resp;
    dm_resp_valid_i = 1'b1;
    wait_for({tag, "_ackhi"}, 1, 1'b1);
    dm_resp_valid_i = 1'b0;
    wait_for({tag, "_acklo"}, 1, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] pat;
    logic [63:0] id_exp;
    pat = 32'h9c3a5e71;

    #22;
    chk("rst_tdo",   tdo_o, 0);
    chk("rst_valid", dtm_req_valid_o, 0);
    chk("rst_data",  dtm_req_data_o, 0);
    chk("rst_ack",   dtm_ack_o, 0);
    @(negedge clk); rst_n = 1'b1;

    // IR reset value selects IDCODE or BYPASS.
    tlr();
`ifdef JTAG_DTM_IDCODE_EN
    id_exp = 64'h1e200a6d;
`else
    id_exp = {32'h0, pat[30:0], 1'b0};
`endif
    dr_scan("idcode", 32, {8'h0, pat}, id_exp);

    ir_scan(5'h10);
    dr_scan("dtmcs_rst", 32, 40'h0, 64'h5061);

    ir_scan(5'h11);
    dr_scan("dmi_rst_cap", 40, 40'h0, 64'h0);

    // Write + full handshake, then capture shows the response.
    dmi_launch("wr1", 40'h137ab6fbbe, 64'h0);
    dm_complete("wr1", {6'h04, 32'h12345678, 2'b00});
    dr_scan("wr1_resp", 40, 40'h0, {24'h0, 6'h04, 32'h12345678, 2'b00});

    // Read of addr 0x11.
    dmi_launch("rd", {6'h11, 32'h0, 2'b01}, {24'h0, 6'h04, 32'h12345678, 2'b00});
    dm_complete("rd", {6'h11, 32'h00430c82, 2'b00});
    dr_scan("rd_resp", 40, 40'h0, {24'h0, 6'h11, 32'h00430c82, 2'b00});

    // Overlapping access: busy status, no new request, sticky error.
    dmi_launch("wr2", {6'h05, 32'hcafef00d, 2'b10}, {24'h0, 6'h11, 32'h00430c82, 2'b00});
    dr_scan("busy_cap", 40, {6'h06, 32'h1, 2'b10}, {24'h0, 6'h11, 32'h00430c82, 2'b11});
    chk("no_new_req", dtm_req_data_o, {6'h05, 32'hcafef00d, 2'b10});
    ir_scan(5'h10);
    dr_scan("dmistat_err", 32, 40'h0, 64'h5c61);
    dm_complete("wr2", {6'h05, 32'h0000beef, 2'b00});
    chk("no_second_valid", dtm_req_valid_o, 0);
    dr_scan("dmireset_wr", 32, 40'h10000, 64'h5c61);
    dr_scan("dmistat_clr", 32, 40'h0, 64'h5061);
    ir_scan(5'h11);
    dr_scan("wr2_resp", 40, 40'h0, {24'h0, 6'h05, 32'h0000beef, 2'b00});

    // Reset while a request is pending.
    dmi_launch("wr3", {6'h07, 32'h55aa55aa, 2'b10}, {24'h0, 6'h05, 32'h0000beef, 2'b00});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", dtm_req_valid_o, 0);
    chk("mid_rst_data",  dtm_req_data_o, 0);
    chk("mid_rst_ack",   dtm_ack_o, 0);
    chk("mid_rst_tdo",   tdo_o, 0);
    @(negedge clk); rst_n = 1'b1;
    tlr();
    ir_scan(5'h11);
    dmi_launch("wr4", {6'h08, 32'h1, 2'b10}, 64'h0);

    // TMS-driven Test-Logic-Reset leaves the handshake alone.
    tlr();
    chk("tlr_valid", dtm_req_valid_o, 1);
    chk("tlr_data",  dtm_req_data_o, {6'h08, 32'h1, 2'b10});
    dm_complete("wr4", {6'h08, 32'h000000a5, 2'b00});
    ir_scan(5'h11);
    dr_scan("wr4_resp", 40, 40'h0, {24'h0, 6'h08, 32'h000000a5, 2'b00});

    chk("sb_empty", 64'(scan_q.size() + req_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jtag_dtm.md
JTAG_DTM -- requirements
Module: jtag_dtm

Interface
REQ-001 parameters: DMI_ADDR_BITS, default 6, DMI address width; DMI_DATA_BITS, default 32, DMI data width; DMI_OP_BITS, default 2, DMI op width; IDCODE_VAL, default 32'h1e200a6d, IDCODE register value.
REQ-002 clk  in  1  JTAG TCK; the whole block runs on it.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 tms_i  in  1  TAP mode select, sampled on posedge clk.
REQ-005 tdi_i  in  1  serial data in, sampled on posedge clk.
REQ-006 tdo_o  out  1  serial data out, updated on negedge clk.
REQ-007 dtm_req_valid_o  out  1  request strobe toward the debug module (DM).
REQ-008 dtm_req_data_o  out  40  {addr[5:0], data[31:0], op[1:0]}; stable while dtm_req_valid_o is high.
REQ-009 dm_ack_i  in  1  DM acknowledge; asynchronous to clk.
REQ-010 dm_resp_valid_i  in  1  DM response strobe; asynchronous to clk.
REQ-011 dm_resp_data_i  in  40  {addr, data, status}; stable while dm_resp_valid_i is high.
REQ-012 dtm_ack_o  out  1  response acknowledge to the DM.

Function
REQ-013 16-state IEEE 1149.1 TAP FSM advances on posedge clk per tms_i; five TMS=1 clocks reach Test-Logic-Reset from any state.
REQ-014 IR is 5 bits. Codes: IDCODE 5'h01, DTMCS 5'h10, DMI 5'h11, BYPASS 5'h1f. Any other code behaves as BYPASS.
REQ-015 Capture-IR loads 5'b00001. Shift-IR shifts LSB first. Update-IR commits. Test-Logic-Reset sets IR to its reset value.
REQ-016 Capture-DR loads per IR: IDCODE_VAL; DTMCS {14'h0, 1'b0, 1'b0, 1'b0, idle 3'd5, dmistat[1:0], abits 6'd6, version 4'd1}; DMI {last_resp_addr, last_resp_data, status}; BYPASS 1'b0.
REQ-017 DMI status = 2'b11 when the sticky busy error is set or a transaction is in flight; otherwise 2'b00.
REQ-018 Shift-DR shifts LSB first; the shift length equals the selected register length (40 for DMI, 32 for others, 1 for BYPASS); tdo_o = shift[0].
REQ-019 Update-DR on DMI with op 2'b01 or 2'b10, not busy, and sticky error clear: latch the 40 bits into dtm_req_data_o, raise dtm_req_valid_o, set busy.
REQ-020 Update-DR on DMI while busy: drop the request and set the sticky error (dmistat 2'b11). op 2'b00 (NOP): no request.
REQ-021 Update-DR on DTMCS: bit16 (dmireset) clears the sticky error; bit17 (dmihardreset) clears the sticky error and busy and drops dtm_req_valid_o. Other bits are ignored.
REQ-022 Request side: four-phase handshake. Hold valid until synced ack=1, then drop valid; the channel is free again when synced ack=0.
REQ-023 Response side: on synced resp_valid=1, latch dm_resp_data_i into last_resp and raise dtm_ack_o. Hold dtm_ack_o until synced resp_valid=0, then drop it and clear busy.
REQ-024 dm_ack_i and dm_resp_valid_i each pass through a two-flop synchronizer; the data buses are sampled only after the synchronized strobe is seen.
REQ-025 busy covers the interval from Update-DR launch until the response handshake completes; a new Update-DR is accepted one cycle after busy clears.

Reset
REQ-026 rst_n low: TAP=Test-Logic-Reset, IR=reset code, shift register=0, tdo_o=0, dtm_req_valid_o=0, dtm_req_data_o=0, dtm_ack_o=0, busy=0, sticky error=0, last_resp=0, synchronizers=0.
REQ-027 Reset asserted mid-handshake abandons the transaction; after release the block is idle and accepts a new request.
REQ-028 Test-Logic-Reset entered via TMS resets only the TAP state and IR; the DMI handshake state is unaffected.

Configuration
REQ-029 Macro JTAG_DTM_IDCODE_EN.
- Defined: IDCODE instruction supported; IR reset value = 5'h01.
- Undefined: IDCODE code behaves as BYPASS; IR reset value = 5'h1f; IDCODE_VAL unused.

Verification
REQ-030 After reset, 5x TMS=1 then shift DR 32 bits -> tdo yields 32'h1e200a6d (IDCODE_EN) / a single 0 followed by TDI echo (undefined).
REQ-031 IR=DTMCS, capture and shift -> 32'h00005061.
REQ-032 IR=DMI, shift {6'h04, 32'hdeadbeef, 2'b10}, Update-DR -> dtm_req_valid_o=1, dtm_req_data_o=40'h137ab6fbbe; DM acks -> valid drops.
REQ-033 DMI read addr 6'h11, DM responds data 32'h430c82 -> after handshake, next DMI capture shows {6'h11, 32'h00430c82, 2'b00}.
REQ-034 Second DMI Update-DR before the DM ack -> no new request, dmistat=3; DTMCS write 32'h10000 -> dmistat=0.
REQ-035 rst_n pulsed while dtm_req_valid_o=1 -> all outputs 0 immediately, next DMI write is accepted.
